// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: expands one 512-bit padded block into the 64-word SHA-256
// message schedule, one word per cycle. The full array stays on W until the
// compression stage releases it with out_ready.
module sha256_msg_sched (
    input  logic                   clk,
    input  logic                   reset,      // asynchronous, active low
    input  logic [511:0]           block_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [0:63][31:0]      W,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [5:0]         r_idx;
    logic [0:63][31:0]  r_w;
    logic               r_out_valid;

    logic [31:0]        w_m2;
    logic [31:0]        w_m7;
    logic [31:0]        w_m15;
    logic [31:0]        w_m16;
    logic [31:0]        w_next;

    // small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Taps for the word being produced; idx is >= 16 whenever they are used,
    // so the 6-bit subtractions never underflow in EXPAND.
    always_comb begin
        w_m2   = r_w[r_idx - 6'd2];
        w_m7   = r_w[r_idx - 6'd7];
        w_m15  = r_w[r_idx - 6'd15];
        w_m16  = r_w[r_idx - 6'd16];
        w_next = f_sig1(w_m2) + w_m7 + f_sig0(w_m15) + w_m16;
    end

    // Control FSM and schedule storage: load, expand one word per edge, hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_idx       <= 6'd0;
            r_w         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= block_in[511 - 32*i -: 32];
                        end
                        r_idx   <= 6'd16;
                        r_state <= EXPAND;
                    end
                end
                EXPAND: begin
                    r_w[r_idx] <= w_next;
                    // idx stops at 63 rather than wrapping back to 0
                    if (r_idx == 6'd63) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Handshake flags decode straight from state; W comes directly from flops.
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = r_out_valid;
        W         = r_w;
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: directed bench with a software schedule model and a
// per-cycle compare of W whenever out_valid is high.
module tb_sha256_msg_sched;

    typedef logic [0:63][31:0] sched_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [511:0]   block_in = '0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    sched_t         W;

    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    sched_t         exp_w = '0;

    sha256_msg_sched dut (
        .clk       (clk),
        .reset     (reset),
        .block_in  (block_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .W         (W),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the SHA-256 recurrence.
    function automatic sched_t model(input logic [511:0] b);
        sched_t s;
        logic [31:0] s0, s1;
        s = '0;
        for (int t = 0; t < 16; t++) s[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(s[t-15], 7) ^ rotr(s[t-15], 18) ^ (s[t-15] >> 3);
            s1   = rotr(s[t-2], 17) ^ rotr(s[t-2], 19) ^ (s[t-2] >> 10);
            s[t] = s1 + s[t-7] + s0 + s[t-16];
        end
        return s;
    endfunction

    function automatic logic [511:0] mk_block(input logic [31:0] seed);
        logic [511:0] b;
        for (int i = 0; i < 16; i++)
            b[511 - 32*i -: 32] = (seed * (i + 1)) ^ {i[7:0], 24'h5A3C0F};
        return b;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // W must equal the model whenever out_valid qualifies it; busy must be high then.
    always @(negedge clk) begin : cmp
        int first;
        if (out_valid) begin
            first = -1;
            for (int t = 0; t < 64; t++)
                if (W[t] !== exp_w[t] && first < 0) first = t;
            total++;
            if (first >= 0 || busy !== 1'b1) begin
                bad++;
                if (first >= 0)
                    $display("FAIL W_hold word=%0d actual=%h required=%h", first, W[first], exp_w[first]);
                else
                    $display("FAIL busy_in_done actual=%b required=1", busy);
            end
        end
    end

    // Called just after a negedge. Presents b until accepted, returns the
    // number of cycles waited, ends just after the negedge following E0.
    task automatic send_block(input logic [511:0] b, input bit hold, output int waited, output int acc_cyc);
        waited = 0;
        block_in = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout actual=%b required=1", in_ready);
        end
        acc_cyc = cyc;
        @(posedge clk);
        exp_w = model(b);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Counts edges after E0 until out_valid is seen; busy must stay high meanwhile.
    task automatic wait_valid(output int k);
        bit busy_ok;
        k = 0;
        busy_ok = 1'b1;
        while (!out_valid && k < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("busy_during_expand", 32'(busy_ok), 32'd1);
    endtask

    // With out_ready already high, out_valid must last exactly n cycles.
    task automatic drain(input int n_exp);
        int n;
        n = 0;
        while (out_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("valid_cycles", 32'(n), 32'(n_exp));
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    logic [511:0] abc, blk_c, blk_d;
    logic [511:0] b2b [3];
    int k, w, acc [3];
    sched_t m;
    bit bp_rdy_ok, bp_vld_ok;

    initial begin
        abc = {32'h61626380, 448'h0, 32'h00000018};
        blk_c = mk_block(32'h9E3779B9);
        blk_d = mk_block(32'h7F4A7C15);
        b2b[0] = mk_block(32'h01000193);
        b2b[1] = abc;
        b2b[2] = mk_block(32'hC2B2AE35);

        // pin the model to known SHA-256 values for "abc"
        m = model(abc);
        check("model_W16", m[16], 32'h61626380);
        check("model_W17", m[17], 32'h000F0000);
        check("model_W63", m[63], 32'h12B1EDEB);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // "abc", out_ready held high
        out_ready = 1'b1;
        send_block(abc, 1'b0, w, acc[0]);
        check("abc_busy_after_E0", 32'(busy), 32'd1);
        check("abc_in_ready_after_E0", 32'(in_ready), 32'd0);
        wait_valid(k);
        check("abc_latency", 32'(k), 32'd48);
        check("abc_W16", W[16], 32'h61626380);
        check("abc_W17", W[17], 32'h000F0000);
        check("abc_W63", W[63], 32'h12B1EDEB);
        drain(1);

        // all-zero block
        send_block('0, 1'b0, w, acc[0]);
        wait_valid(k);
        check("zero_latency", 32'(k), 32'd48);
        check("zero_W63", W[63], 32'h0);
        drain(1);

        // backpressure: hold 100 cycles while a new block waits
        out_ready = 1'b0;
        send_block(blk_c, 1'b0, w, acc[0]);
        wait_valid(k);
        check("bp_latency", 32'(k), 32'd48);
        block_in = blk_d;
        in_valid = 1'b1;
        bp_rdy_ok = 1'b1;
        bp_vld_ok = 1'b1;
        repeat (100) begin
            @(posedge clk);
            @(negedge clk);
            if (in_ready !== 1'b0) bp_rdy_ok = 1'b0;
            if (out_valid !== 1'b1) bp_vld_ok = 1'b0;
        end
        check("bp_in_ready_low", 32'(bp_rdy_ok), 32'd1);
        check("bp_out_valid_high", 32'(bp_vld_ok), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        send_block(blk_d, 1'b0, w, acc[0]);
        check("bp_accept_wait", 32'(w), 32'd0);
        wait_valid(k);
        check("bp2_latency", 32'(k), 32'd48);
        out_ready = 1'b1;
        drain(1);

        // reset mid-EXPAND at idx=30
        send_block(abc, 1'b0, w, acc[0]);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_W_zero", 32'(W == '0), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        send_block(abc, 1'b0, w, acc[0]);
        check("postrst_accept_wait", 32'(w), 32'd0);
        wait_valid(k);
        check("postrst_latency", 32'(k), 32'd48);
        check("postrst_W63", W[63], 32'h12B1EDEB);
        drain(1);

        // back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 3; i++)
            send_block(b2b[i], (i < 2), w, acc[i]);
        check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd50);
        check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd50);
        wait_valid(k);
        check("b2b_latency", 32'(k), 32'd48);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Message-schedule expander that sits directly upstream of the SHA-256 compression pipe. It accepts one 512-bit padded message block and expands it into the 64-word schedule W[0:63]. It computes one word per cycle and holds the full array stable on its output until the compression stage releases it. The output array drives the compression pipe's W input directly.

## Interface
- Parameters: none. All widths are fixed by SHA-256: 32-bit words, 16 input words, 64 output words.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- block_in  input  512  padded message block. Word 0 is bits [511:480]; word 15 is bits [31:0].
- in_valid  input  1  block_in is valid.
- in_ready  output  1  block can be accepted this cycle; high only in IDLE.
- W  output  64x32 (packed [0:63][31:0])  schedule array; W[t] is word t.
- out_valid  output  1  W[0:63] is complete and stable.
- out_ready  input  1  consumer releases W; sampled only while out_valid is high.
- busy  output  1  high in EXPAND or DONE.

## Operation
- States: IDLE, EXPAND, DONE. Internal word index idx is 6 bits.
- IDLE
  - in_ready=1.
  - On an edge with in_valid=1: load W[0..15] from block_in, set idx<=16, go to EXPAND.
  - in_valid=0: stay in IDLE.
- EXPAND
  - Each edge: W[idx] <= σ1(W[idx-2]) + W[idx-7] + σ0(W[idx-15]) + W[idx-16], mod 2^32. Then idx<=idx+1.
  - On the edge that writes W[63]: go to DONE and set out_valid<=1.
  - in_valid is ignored.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- All additions are 32-bit and wrap; carries are discarded.
- DONE
  - out_valid=1. W holds every bit stable.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE. W keeps its contents until the next load.
- Words W[0..idx-1] are final as soon as they are written. Downstream must not rely on this: only out_valid qualifies W.
- idx never wraps; the transition to DONE happens at idx==63.
- reset low, at any time including mid-EXPAND or in DONE: the in-flight block is aborted and all state below is forced immediately.
  - state=IDLE, idx=0, W all zero.
  - out_valid=0, busy=0, in_ready=1.
- Reset release does not need in_valid to be low. A block presented in the first cycle after release is accepted.

## Timing
- Acceptance edge is E0 (in_valid & in_ready). W[0..15] are valid after E0.
- W[t] for t≥16 is written at edge E0+(t-15).
- out_valid rises after edge E0+48. busy is high from after E0 until the release edge.
- Release edge is ER (out_valid & out_ready). IDLE is entered after ER, and the earliest next acceptance is ER+1.
- Minimum block period is 50 cycles: 1 load, 48 expand, at least 1 DONE cycle.
- out_ready held high before out_valid rises gives a single DONE cycle. out_ready outside DONE has no effect.
- in_ready and busy are decoded combinationally from state. out_valid is a register.
- W is driven straight from flops, with no combinational path from any input.
- The consumer must hold out_ready low for its full compression run (66 cycles) so W stays stable while it indexes W[counter].

## Test plan
- Reset values: assert reset low mid-stream -> out_valid=0, busy=0, in_ready=1 and W all zero, all within the reset assertion with no clock edge needed.
- "abc" block (word0=0x61626380, words1-14=0, word15=0x00000018), out_ready=1:
  - W[16]=0x61626380, W[17]=0x000F0000, W[63]=0x12B1EDEB.
  - out_valid high exactly 48 cycles after acceptance, for exactly 1 cycle.
- All-zero block -> W[0..63] all 0x00000000. Check that out_valid and the E0+48 latency are unchanged.
- Backpressure:
  - Hold out_ready=0 for 100 cycles after out_valid -> W bit-stable and out_valid stays high.
  - Present a new in_valid block during this time -> in_ready=0 and the block is not loaded.
  - Pulse out_ready -> IDLE on the next edge and the new block is accepted one cycle later.
- Reset mid-EXPAND at idx=30 -> state aborted and W cleared. A fresh "abc" block after release gives the correct W[63]=0x12B1EDEB.
- Back-to-back blocks with out_ready=1 and in_valid=1 continuously -> acceptances exactly 50 cycles apart and each W matches the software reference model.
